mips_bus_arbiter: RTL and testbench
===================================

# mips_bus_arbiter

Parametrised multi-channel bus master for the multicycle MIPS core. It arbitrates CHANNELS independent requesters onto the single Avalon-style memory bus: read, write, address, writedata, byteenable, waitrequest and readdata. Typical requesters are instruction fetch, load/store and a future debug port. Arbitration is round-robin. Every bus output is registered, and each completed transfer is returned to its requester as a one-cycle ready pulse.

## Interface
Parameters:
- CHANNELS, default 2: number of requesters, 1–8.
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width, a multiple of 8. BE_W = DATA_W/8.

Ports:
- clk, input, 1: sole clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-low.
- ch_req, input, CHANNELS: per-channel request, level-sensitive.
- ch_write, input, CHANNELS: 1 = write, 0 = read.
- ch_address, input, CHANNELS*ADDR_W: channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_writedata, input, CHANNELS*DATA_W: write data per channel.
- ch_byteenable, input, CHANNELS*BE_W: byte lanes per channel.
- ch_ready, output, CHANNELS: one-cycle completion pulse for the granted channel.
- ch_readdata, output, DATA_W: read result, valid while ch_ready is high.
- grant, output, $clog2(CHANNELS) (minimum 1): index of the channel owning the current transaction.
- busy, output, 1: high in every state except IDLE.
- address, output, ADDR_W: bus address. Low $clog2(BE_W) bits are always 0.
- read, output, 1: bus read strobe.
- write, output, 1: bus write strobe.
- writedata, output, DATA_W: bus write data.
- byteenable, output, BE_W: bus byte enables.
- waitrequest, input, 1: slave stall.
- readdata, input, DATA_W: slave read data, valid exactly one cycle after the accepted read.

## Operation
FSM states: IDLE, ISSUE, RDATA, RESP.

- IDLE
  - If any ch_req is high, pick the winner round-robin. Search starts at last_grant+1 and wraps modulo CHANNELS.
  - Capture the winner's write flag, address (low bits zeroed), writedata and byteenable into the bus output registers. Load grant and last_grant. Go to ISSUE.
  - If the captured byteenable is 0, go straight to RESP with no bus strobe.
  - If no request is pending, stay in IDLE.
- ISSUE
  - Drive read = ~wr or write = wr. Hold address, writedata and byteenable stable.
  - waitrequest=1: stay.
  - waitrequest=0: drop the strobe. Writes go to RESP, reads go to RDATA.
- RDATA: capture readdata into the ch_readdata register, then go to RESP.
- RESP: pulse ch_ready[grant] for exactly one cycle, then go to IDLE. No arbitration happens in RESP.

Requester and boundary rules:
- Requester fields need only be valid in the IDLE cycle when the grant is taken. After that they are ignored until RESP.
- A requester must drop or replace its ch_req by the edge that ends its ch_ready cycle. A still-high ch_req is treated as a new request.
- Withdrawing ch_req before grant is legal and causes no transfer.
- With CHANNELS=1, the arbiter always grants channel 0.
- Unused ch_ready bits stay 0.
- ch_readdata holds its last captured value between reads. Writes do not modify it.
- Only one transaction is ever outstanding.

## Timing
Reset behaviour, when reset=0 at a rising edge:
- state becomes IDLE.
- read, write, address, writedata, byteenable, ch_ready, ch_readdata, grant and busy all become 0.
- last_grant becomes CHANNELS-1, so channel 0 wins first after reset.

Reset has priority over everything, including mid-ISSUE: the strobe drops at that edge and the transaction is discarded with no ready pulse.

Latency with waitrequest=0 throughout, counted from the IDLE cycle in which the request is sampled:
- Read: strobe in cycle +1, readdata in cycle +2, ch_ready in cycle +3.
- Write: strobe in cycle +1, ch_ready in cycle +2.
- Each waitrequest=1 cycle adds one cycle.
- Zero-byteenable request: ch_ready in cycle +1.

Throughput:
- Back-to-back reads from one channel: one per 4 cycles.
- Writes: one per 3 cycles.

## Test plan
- Reset, then a channel-0 read of 0x0000_1003 (byteenable 4'hF), with the slave returning 0xDEADBEEF after 0 waits:
  - bus address is 0x0000_1000 and read is high exactly one cycle;
  - ch_ready[0] and ch_readdata = 0xDEADBEEF occur 3 cycles after the request.
- Channel-1 write of 0x12345678 with byteenable 4'b0011 and 3 waitrequest cycles:
  - write, address and writedata are stable for 4 cycles;
  - ch_ready[1] arrives 5 cycles after the request;
  - ch_readdata is unchanged.
- Both channels requesting continuously with CHANNELS=2: grants alternate 0,1,0,1. Repeat with CHANNELS=3 and all requesting: 0,1,2,0.
- Zero-byteenable write on channel 0: no read or write strobe ever; ch_ready[0] arrives 1 cycle after the request.
- Reset asserted during the second waitrequest cycle of a read:
  - read drops at that edge, with no ch_ready pulse;
  - all outputs are 0;
  - the next request from channel 1 while channel 0 also requests is granted to channel 0.
- ch_req[0] withdrawn while channel 1 holds the bus: after channel 1's RESP, the arbiter stays in IDLE with busy=0 and no bus strobes.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_bus_arbiter
// Purpose  : Round-robin arbiter multiplexing CHANNELS requesters onto a single
//            registered Avalon-style memory bus, one transaction at a time.
// Revision : 1.0 - initial release
// ============================================================================
module mips_bus_arbiter #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  localparam int BE_W    = DATA_W / 8,
  localparam int GRANT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        ch_req,
  input  logic [CHANNELS-1:0]        ch_write,
  input  logic [CHANNELS*ADDR_W-1:0] ch_address,
  input  logic [CHANNELS*DATA_W-1:0] ch_writedata,
  input  logic [CHANNELS*BE_W-1:0]   ch_byteenable,
  output logic [CHANNELS-1:0]        ch_ready,
  output logic [DATA_W-1:0]          ch_readdata,
  output logic [GRANT_W-1:0]         grant,
  output logic                       busy,
  output logic [ADDR_W-1:0]          address,
  output logic                       read,
  output logic                       write,
  output logic [DATA_W-1:0]          writedata,
  output logic [BE_W-1:0]            byteenable,
  input  logic                       waitrequest,
  input  logic [DATA_W-1:0]          readdata
);

  localparam int                 c_lane_bits = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam logic [ADDR_W-1:0]  c_addr_mask = {ADDR_W{1'b1}} << c_lane_bits;
  localparam logic [GRANT_W-1:0] c_last_rst  = GRANT_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RDATA = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state, w_state_n;
  logic [GRANT_W-1:0]   r_last_grant, w_last_grant_n;
  logic                 r_wr, w_wr_n;

  logic                 w_found;
  logic [GRANT_W-1:0]   w_win;
  logic                 w_sel_wr;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;
  logic [BE_W-1:0]      w_sel_be;

  logic                 w_read_n, w_write_n, w_busy_n, w_ready_set;
  logic [ADDR_W-1:0]    w_address_n;
  logic [DATA_W-1:0]    w_writedata_n, w_readdata_n;
  logic [BE_W-1:0]      w_byteenable_n;
  logic [GRANT_W-1:0]   w_grant_n;
  logic [CHANNELS-1:0]  w_ready_n;

  // Search begins one past the previous winner so every requester is served in turn.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int off = 1; off <= CHANNELS; off++) begin
      idx = int'(r_last_grant) + off;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!w_found && ch_req[idx]) begin
        w_found = 1'b1;
        w_win   = idx[GRANT_W-1:0];
      end
    end
  end

  assign w_sel_wr    = ch_write[w_win];
  assign w_sel_addr  = ch_address[int'(w_win)*ADDR_W +: ADDR_W];
  assign w_sel_wdata = ch_writedata[int'(w_win)*DATA_W +: DATA_W];
  assign w_sel_be    = ch_byteenable[int'(w_win)*BE_W +: BE_W];

  always_comb begin
    w_state_n      = r_state;
    w_last_grant_n = r_last_grant;
    w_wr_n         = r_wr;
    w_read_n       = read;
    w_write_n      = write;
    w_address_n    = address;
    w_writedata_n  = writedata;
    w_byteenable_n = byteenable;
    w_grant_n      = grant;
    w_readdata_n   = ch_readdata;
    w_ready_set    = 1'b0;
    w_ready_n      = '0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_n      = w_win;
          w_last_grant_n = w_win;
          w_wr_n         = w_sel_wr;
          w_address_n    = w_sel_addr & c_addr_mask;
          w_writedata_n  = w_sel_wdata;
          w_byteenable_n = w_sel_be;
          // An empty byte mask completes without touching the bus.
          if (w_sel_be == '0) begin
            w_state_n   = S_RESP;
            w_ready_set = 1'b1;
          end else begin
            w_state_n = S_ISSUE;
            w_read_n  = ~w_sel_wr;
            w_write_n = w_sel_wr;
          end
        end
      end
      S_ISSUE: begin
        if (!waitrequest) begin
          w_read_n  = 1'b0;
          w_write_n = 1'b0;
          if (r_wr) begin
            w_state_n   = S_RESP;
            w_ready_set = 1'b1;
          end else begin
            w_state_n = S_RDATA;
          end
        end
      end
      S_RDATA: begin
        w_readdata_n = readdata;
        w_state_n    = S_RESP;
        w_ready_set  = 1'b1;
      end
      S_RESP: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    if (w_ready_set) begin
      for (int i = 0; i < CHANNELS; i++) begin
        w_ready_n[i] = (w_grant_n == i[GRANT_W-1:0]);
      end
    end
    w_busy_n = (w_state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= c_last_rst;
      r_wr         <= 1'b0;
      read         <= 1'b0;
      write        <= 1'b0;
      address      <= '0;
      writedata    <= '0;
      byteenable   <= '0;
      ch_ready     <= '0;
      ch_readdata  <= '0;
      grant        <= '0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_last_grant <= w_last_grant_n;
      r_wr         <= w_wr_n;
      read         <= w_read_n;
      write        <= w_write_n;
      address      <= w_address_n;
      writedata    <= w_writedata_n;
      byteenable   <= w_byteenable_n;
      ch_ready     <= w_ready_n;
      ch_readdata  <= w_readdata_n;
      grant        <= w_grant_n;
      busy         <= w_busy_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_bus_arbiter
// Purpose  : Randomised bench for mips_bus_arbiter against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    ch_req, ch_write, ch_ready;
  logic [N*AW-1:0] ch_address;
  logic [N*DW-1:0] ch_writedata;
  logic [N*BW-1:0] ch_byteenable;
  logic [DW-1:0]   ch_readdata;
  logic            grant;
  logic            busy;
  logic [AW-1:0]   address;
  logic            read, write;
  logic [DW-1:0]   writedata;
  logic [BW-1:0]   byteenable;
  logic            waitrequest;
  logic [DW-1:0]   readdata;

  logic [2:0]      req3, write3, ready3;
  logic [3*AW-1:0] address3_in;
  logic [3*DW-1:0] wdata3_in;
  logic [3*BW-1:0] be3_in;
  logic [DW-1:0]   rdata3_out;
  logic [1:0]      grant3;
  logic            busy3, read3, write3_out;
  logic [AW-1:0]   address3;
  logic [DW-1:0]   writedata3;
  logic [BW-1:0]   byteenable3;

  int n_tests = 0;
  int n_fail  = 0;
  int last    = N - 1;
  logic [DW-1:0] exp_rdata = '0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.CHANNELS(N), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_write(ch_write),
    .ch_address(ch_address), .ch_writedata(ch_writedata), .ch_byteenable(ch_byteenable),
    .ch_ready(ch_ready), .ch_readdata(ch_readdata), .grant(grant), .busy(busy),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  mips_bus_arbiter #(.CHANNELS(3), .ADDR_W(AW), .DATA_W(DW)) u_dut3 (
    .clk(clk), .reset(reset), .ch_req(req3), .ch_write(write3),
    .ch_address(address3_in), .ch_writedata(wdata3_in), .ch_byteenable(be3_in),
    .ch_ready(ready3), .ch_readdata(rdata3_out), .grant(grant3), .busy(busy3),
    .address(address3), .read(read3), .write(write3_out), .writedata(writedata3),
    .byteenable(byteenable3), .waitrequest(1'b0), .readdata(32'h0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester after the previous winner, wrapping.
  function automatic int rr_pick(input int n, input int mask, input int prev);
    for (int j = 1; j <= n; j++) begin
      int c;
      c = (prev + j) % n;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      ch_write[i] = 1'($urandom);
      ch_address[i*AW +: AW] = $urandom;
      ch_writedata[i*DW +: DW] = $urandom;
      ch_byteenable[i*BW +: BW] = 4'($urandom);
    end
  endtask

  // One complete transaction, checked cycle by cycle from the request cycle on.
  task automatic round(input int mask, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [BW-1:0] be,
                       input int waits, input logic [DW-1:0] rd);
    int w;
    w = rr_pick(N, mask, last);
    scramble();
    ch_req = mask[N-1:0];
    ch_write[w] = wr;
    ch_address[w*AW +: AW] = addr;
    ch_writedata[w*DW +: DW] = wd;
    ch_byteenable[w*BW +: BW] = be;
    waitrequest = (waits > 0);
    step();
    last = w;
    ch_req = '0;
    scramble();
    if (be == '0) begin
      check("zbe_strobes", {read, write}, 0);
    end else begin
      for (int k = 0; k <= waits; k++) begin
        waitrequest = (k < waits);
        check("strobe_read", read, !wr);
        check("strobe_write", write, wr);
        check("bus_address", address, addr & ~32'h3);
        check("bus_writedata", writedata, wd);
        check("bus_byteenable", byteenable, be);
        check("issue_grant", grant, w);
        check("issue_busy", busy, 1);
        check("issue_no_ready", ch_ready, 0);
        step();
      end
      waitrequest = 1'b0;
      if (!wr) begin
        check("rdata_strobes_off", {read, write}, 0);
        check("rdata_no_ready", ch_ready, 0);
        readdata = rd;
        step();
        readdata = $urandom;
        exp_rdata = rd;
      end
    end
    check("ready_pulse", ch_ready, 64'(1) << w);
    check("ready_grant", grant, w);
    check("ready_busy", busy, 1);
    check("ready_strobes_off", {read, write}, 0);
    check("ready_readdata", ch_readdata, exp_rdata);
    step();
    check("idle_busy", busy, 0);
    check("idle_ready", ch_ready, 0);
    check("idle_strobes", {read, write}, 0);
  endtask

  initial begin
    int last3, pulses;
    ch_req = '0; waitrequest = 1'b0; readdata = $urandom;
    req3 = '0; write3 = '1; address3_in = '0; wdata3_in = '0; be3_in = '1;
    scramble();
    reset = 1'b0;
    repeat (3) step();
    check("rst_outputs", {read, write, busy, grant, ch_ready}, 0);
    check("rst_bus", {address, writedata, byteenable}, 0);
    check("rst_readdata", ch_readdata, 0);
    reset = 1'b1;
    step();

    round(1, 1'b0, 32'h0000_1003, $urandom, 4'hF, 0, 32'hDEADBEEF);
    round(2, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 3, $urandom);
    for (int i = 0; i < 4; i++) round(3, 1'b0, $urandom, $urandom, 4'hF, 0, $urandom);
    round(1, 1'b1, $urandom, $urandom, 4'h0, 0, $urandom);

    // Reset during the second wait cycle of a channel-0 read.
    ch_req = 2'b01; ch_write[0] = 1'b0; ch_byteenable[0 +: BW] = 4'hF;
    ch_address[0 +: AW] = 32'h0000_0040;
    waitrequest = 1'b1;
    step();
    ch_req = '0;
    check("rstmid_read1", read, 1);
    step();
    check("rstmid_read2", read, 1);
    reset = 1'b0;
    step();
    check("rstmid_strobes", {read, write, busy, ch_ready}, 0);
    check("rstmid_bus", {address, writedata, byteenable, grant}, 0);
    check("rstmid_readdata", ch_readdata, 0);
    reset = 1'b1;
    waitrequest = 1'b0;
    last = N - 1;
    exp_rdata = '0;
    round(3, 1'b0, $urandom, $urandom, 4'hF, 1, $urandom);
    round(3, 1'b1, $urandom, $urandom, 4'hC, 0, $urandom);
    step();
    check("withdraw_idle", {busy, read, write, ch_ready}, 0);

    for (int r = 0; r < 60; r++) begin
      logic [BW-1:0] be;
      be = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      round($urandom_range(1, 3), 1'($urandom), $urandom, $urandom, be,
            $urandom_range(0, 3), $urandom);
    end

    // Three requesters holding their requests continuously.
    req3 = 3'b111;
    last3 = 2;
    pulses = 0;
    for (int c = 0; c < 40 && pulses < 4; c++) begin
      step();
      if (ready3 != '0) begin
        int w3;
        w3 = rr_pick(3, 7, last3);
        check("rr3_ready", ready3, 64'(1) << w3);
        check("rr3_grant", grant3, w3);
        last3 = w3;
        pulses++;
      end
    end
    req3 = '0;
    check("rr3_pulse_count", pulses, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
